// File: rtl/adder_rr_sched_pkg.sv
// Shared constants and types for the round-robin adder scheduler.
package adder_rr_sched_pkg;

  localparam int W     = 16;
  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
    logic         last;
  } rsp_t;

endpackage

// File: rtl/adder_rr_sched_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic       found_s;
  logic [1:0] cand_s;

  // Scan the four positions starting at ptr; the first hit wins.
  always_comb begin
    grant   = 4'b0000;
    idx     = ptr;
    found_s = 1'b0;
    cand_s  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand_s = ptr + 2'(k);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external adder among four requesters,
// with multi-word chaining (lock + carry forwarding) and a tagged response register.
module adder_rr_sched
  import adder_rr_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  input  logic [N_REQ-1:0]     req_cin,
  input  logic [N_REQ-1:0]     req_last,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_last
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [1:0]         rr_ptr_r;
  logic [1:0]         owner_r;
  logic               carry_r;
  logic               rsp_valid_r;
  rsp_t               rsp_r;

  logic [N_REQ-1:0]   pick_grant_s;
  logic [1:0]         pick_idx_s;
  logic [N_REQ-1:0]   grant_s;
  logic [1:0]         win_s;
  logic               any_s;
  logic               stall_s;
  logic               accept_s;
  logic               last_s;

  rr_pick4 u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s)
  );

  // Grant selection: free arbitration in IDLE, owner-only while locked.
  always_comb begin
    grant_s = 4'b0000;
    win_s   = pick_idx_s;
    case (state_r)
      IDLE: begin
        grant_s = pick_grant_s;
        win_s   = pick_idx_s;
      end
      LOCK: begin
        grant_s[owner_r] = req_valid[owner_r];
        win_s            = owner_r;
      end
      default: begin
        grant_s = 4'b0000;
        win_s   = 2'd0;
      end
    endcase
  end

  assign any_s     = |grant_s;
  assign stall_s   = rsp_valid_r & ~rsp_ready;
  assign accept_s  = any_s & ~stall_s;
  assign last_s    = req_last[win_s];
  assign req_ready = grant_s & {N_REQ{~stall_s}};

  // Operand mux toward the shared adder; chained beats take the stored carry.
  always_comb begin
    add_a   = {W{1'b0}};
    add_b   = {W{1'b0}};
    add_cin = 1'b0;
    if (any_s) begin
      add_a   = req_a[32'(win_s)*W +: W];
      add_b   = req_b[32'(win_s)*W +: W];
      add_cin = (state_r == LOCK) ? carry_r : req_cin[win_s];
    end else begin
      add_cin = 1'b0;
    end
  end

  // Next-state: a non-final accepted beat locks, a final one releases.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      state_nxt_s = last_s ? IDLE : LOCK;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: response stage, carry chain, owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_r       <= '0;
      carry_r     <= 1'b0;
      owner_r     <= 2'd0;
      rr_ptr_r    <= 2'd0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_r       <= '{id: win_s, sum: add_sum, cout: add_cout, last: last_s};
      carry_r     <= add_cout;
      owner_r     <= win_s;
      if (last_s) begin
        rr_ptr_r <= win_s + 2'd1;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_r.id;
  assign rsp_sum   = rsp_r.sum;
  assign rsp_cout  = rsp_r.cout;
  assign rsp_last  = rsp_r.last;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Self-checking bench: behavioural scheduler model, directed scenarios and random traffic.
module tb_adder_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_cin, req_last;
  logic [63:0] req_a, req_b;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_cout, rsp_last;

  always #5 clk = ~clk;

  // The bench plays the role of the external adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  adder_rr_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_lock;
  int          m_owner, m_ptr;
  bit          m_carry, m_rv;
  int          m_id;
  logic [15:0] m_sum;
  bit          m_cout, m_last;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    req_valid = 4'b0; req_cin = 4'b0; req_last = 4'b0;
    req_a = 64'd0; req_b = 64'd0;
  endtask

  task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic cin, logic last);
    req_valid[i] = 1'b1;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_cin[i] = cin;
    req_last[i] = last;
  endtask

  // One clock: check outputs at negedge against the model, advance model, return at posedge+1.
  task automatic step();
    bit          stall;
    int          win;
    logic [3:0]  exp_ready;
    logic [15:0] ea, eb;
    logic        ec;
    logic [16:0] tot;
    @(negedge clk);
    stall = m_rv && !rsp_ready;
    win = -1;
    if (m_lock) begin
      if (req_valid[m_owner]) win = m_owner;
    end else begin
      for (int k = 0; k < 4; k++)
        if (win < 0 && req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    end
    exp_ready = 4'b0;
    if (win >= 0 && !stall) exp_ready[win] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_cout", rsp_cout, m_cout);
      chk("rsp_last", rsp_last, m_last);
    end
    if (win >= 0 && !stall) begin
      ea = req_a[win*16 +: 16];
      eb = req_b[win*16 +: 16];
      ec = m_lock ? m_carry : req_cin[win];
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      chk("add_cin", add_cin, ec);
      tot = {1'b0, ea} + {1'b0, eb} + {16'd0, ec};
      m_rv = 1; m_id = win; m_sum = tot[15:0]; m_cout = tot[16]; m_last = req_last[win];
      m_carry = tot[16];
      if (req_last[win]) begin
        m_lock = 0;
        m_ptr = (win + 1) % 4;
      end else begin
        m_lock = 1;
        m_owner = win;
      end
    end else if (rsp_ready) begin
      m_rv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_cin", add_cin, 0);
    m_lock = 0; m_owner = 0; m_ptr = 0; m_carry = 0; m_rv = 0;
    m_id = 0; m_sum = 16'd0; m_cout = 0; m_last = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] held_sum;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_idle();
    #3;
    do_reset();

    // Single add, then pointer has moved to 1
    set_req(0, 16'h1234, 16'h0FED, 1'b1, 1'b1);
    step();
    chk("single_id", rsp_id, 0);
    chk("single_sum", rsp_sum, 16'h2222);
    chk("single_cout", rsp_cout, 0);
    set_idle();
    set_req(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
    set_req(1, 16'h0002, 16'h0002, 1'b0, 1'b1);
    step();
    chk("ptr_moved_id", rsp_id, 1);

    // Overflow
    set_idle();
    set_req(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step();
    chk("ovf_sum", rsp_sum, 16'h0000);
    chk("ovf_cout", rsp_cout, 1);

    // Fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'(i * 3), 16'(i + 7), 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_valid", rsp_valid, 1);
      chk("fair_id", rsp_id, k % 4);
    end

    // Chain on req 2 with req 1 waiting; first steer the pointer to 2
    set_idle();
    set_req(1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    step();
    set_idle();
    set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    set_req(1, 16'h0003, 16'h0004, 1'b0, 1'b1);
    step();
    chk("chain0_id", rsp_id, 2);
    chk("chain0_sum", rsp_sum, 16'h0000);
    chk("chain0_cout", rsp_cout, 1);
    chk("chain0_last", rsp_last, 0);
    set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step();
    chk("chain1_id", rsp_id, 2);
    chk("chain1_sum", rsp_sum, 16'h0001);
    chk("chain1_cout", rsp_cout, 0);
    req_valid[2] = 1'b0;
    step();
    chk("after_chain_id", rsp_id, 1);
    chk("after_chain_sum", rsp_sum, 16'h0007);

    // Backpressure
    set_idle();
    set_req(0, 16'h0010, 16'h0020, 1'b0, 1'b1);
    step();
    rsp_ready = 1'b0;
    set_idle();
    set_req(3, 16'h0100, 16'h0200, 1'b0, 1'b1);
    held_sum = 16'h0030;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      step();
      chk("bp_hold_sum", rsp_sum, held_sum);
      chk("bp_hold_id", rsp_id, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b1000);
    step();
    chk("bp_new_id", rsp_id, 3);
    chk("bp_new_sum", rsp_sum, 16'h0300);

    // Reset mid-chain drops the stored carry
    set_idle();
    set_req(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step();
    do_reset();
    set_req(3, 16'h0005, 16'h0006, 1'b0, 1'b1);
    #1;
    chk("post_rst_cin", add_cin, 0);
    step();
    chk("post_rst_id", rsp_id, 3);
    chk("post_rst_sum", rsp_sum, 16'h000B);
    chk("post_rst_cout", rsp_cout, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom);
      req_cin   = 4'($urandom);
      req_last  = 4'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
# adder_rr_sched

Round-robin scheduler that shares one 16-bit adder datapath between four requesters. It accepts add beats over per-requester valid/ready handshakes and drives the shared adder's operands and carry-in. It registers the adder result into a single tagged response stage. It also supports multi-word (chained) additions: a requester holds the adder across beats, and each beat consumes the carry-out of the previous one. The block sits between the partial-product generators of the multiplier and the single shared adder instance.

## Interface
Parameters:
- N_REQ, 4: number of requesters (fixed at 4 for this block).
- W, 16: operand width, equal to the shared adder width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  beat offered by requester i.
- req_ready  out  N_REQ  beat accepted when valid & ready; may depend combinationally on req_valid.
- req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N_REQ*W  operand B, same packing.
- req_cin  in  N_REQ  carry-in for a requester's first beat.
- req_last  in  N_REQ  beat is the final word of the operation; 1 for single-word adds.
- add_a, add_b  out  W  operands to the shared adder (combinational from the granted requester).
- add_cin  out  1  carry to the shared adder.
- add_sum  in  W  adder sum, combinational return.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  response held in the output register.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  2  requester index of the response.
- rsp_sum  out  W  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_last  out  1  copy of req_last for the beat.

## Operation
- The FSM has two states:
  - IDLE: the grant goes to the first valid requester at or after rr_ptr, searching modulo 4.
  - LOCK: only the owner is granted, and the other requesters' ready stays 0.
- Stall condition: stall = rsp_valid & ~rsp_ready. While stalled, all req_ready are 0 and the adder outputs are don't-care.
- req_ready[i] = grant[i] & ~stall.
- add_cin is:
  - req_cin[owner] in IDLE.
  - carry_q in LOCK.
- On an accepted beat:
  - The response register loads {id, add_sum, add_cout, req_last}.
  - carry_q is set to add_cout.
- State transitions on an accepted beat:
  - IDLE with last=0: go to LOCK, owner = winner.
  - LOCK with last=1: go to IDLE.
  - IDLE with last=1: stay in IDLE.
- rr_ptr becomes (winner+1) mod 4 only when an operation completes, i.e. on an accepted beat with last=1.
- An owner in LOCK that deasserts valid leaves a bubble. The lock holds, and there is no timeout.
- When rsp_valid & rsp_ready and no new accept occurs, rsp_valid clears.
- Arithmetic is modulo 2^W, and cout reports overflow per beat.

## Timing
- Latency: a beat accepted at edge t gives rsp_valid=1 with the result after edge t.
- Throughput: one beat per cycle while rsp_ready=1.
- Reset (asynchronous, active-high) clears:
  - rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last to 0.
  - state to IDLE, rr_ptr to 0, carry_q to 0, owner to 0.
- Reset mid-chain drops the lock and the partial result. The requester must restart its operation.
- When accept and response drain happen in the same cycle, the new beat replaces the old response with no bubble.
- With simultaneous requests in IDLE, the lowest index at or after rr_ptr wins.
- A late-arriving requester never preempts a LOCK.

## Structure
- The shared package holds:
  - the constants W=16 and N_REQ=4.
  - the state enum {IDLE, LOCK}.
  - the response struct {id, sum, cout, last}.
- Sub-module rr_pick4 is combinational: inputs req[3:0] and ptr[1:0], outputs a one-hot grant and index. Its search wraps modulo 4.
- The top level contains the FSM, carry_q, rr_ptr, the response register and the operand muxes. The adder itself is external.

## Test plan
- Single add: req 0, a=0x1234, b=0x0FED, cin=1, last=1 -> next cycle rsp_id=0, sum=0x2222, cout=0; rr_ptr becomes 1.
- Overflow: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
- Fairness: all four requesters valid for 8 beats, all single-word, rsp_ready=1 -> ids 0,1,2,3,0,1,2,3 with no idle cycles.
- Chained 32-bit add on req 2:
  - stimulus: beat0 a=0xFFFF, b=0x0001, last=0; beat1 a=0x0000, b=0x0000, last=1.
  - response: sum 0x0000/cout 1, then 0x0001/cout 0.
  - check: req 1, held valid throughout, is granted only after beat1.
- Backpressure: rsp_ready=0 for 3 cycles with a response pending -> all req_ready=0 and the rsp fields are stable; when rsp_ready rises, the next beat is accepted in the same cycle.
- Reset mid-chain: assert rst after beat0 of a chain -> all outputs are 0 and the FSM returns to IDLE; after release, req 3 single-word is granted with add_cin=req_cin[3], not the stale carry.
